// File: rtl/fetch_unit.sv
// Instruction fetch: PC register and IF/ID register with valid/ready back-pressure.
// Define FETCH_JUMP_PREDECODE_EN to redirect `j` inside fetch with no bubble.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
`ifdef FETCH_JUMP_PREDECODE_EN
  , parameter logic [3:0] JUMP_OPCODE = 4'b1100
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] PC,
  input  logic [15:0] instruction,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] outInstr,
  output logic [15:0] outPC,
  output logic        outJumpTaken,
  output logic [15:0] fetchCount
);

  logic [15:0] pc_q, pc_d;
  logic        valid_q;
  logic [15:0] instr_q;
  logic [15:0] opc_q;
  logic        jump_q, jump_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load;

  assign load = !(valid_q && !outReady);

  always_comb begin
    pc_d   = pc_q + 16'd1;
    jump_d = 1'b0;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (instruction[15:12] == JUMP_OPCODE) begin
      pc_d   = {pc_q[15:12], instruction[11:0]};
      jump_d = 1'b1;
    end
`endif
  end

  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 16'h0000;
      opc_q   <= 16'h0000;
      jump_q  <= 1'b0;
      cnt_q   <= 16'h0000;
    end else if (redirect) begin
      // Squash the wrong-path instruction even if decode is stalled.
      pc_q    <= redirectPC;
      valid_q <= 1'b0;
    end else if (load) begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      instr_q <= instruction;
      opc_q   <= pc_q;
      jump_q  <= jump_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC           = pc_q;
  assign outValid     = valid_q;
  assign outInstr     = instr_q;
  assign outPC        = opc_q;
  assign outJumpTaken = jump_q;
  assign fetchCount   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected accepted (pc, instr)
// pairs are queued before stimulus and popped on each acceptance.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] PC;
  logic [15:0] instruction;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        outValid;
  logic        outReady;
  logic [15:0] outInstr;
  logic [15:0] outPC;
  logic        outJumpTaken;
  logic [15:0] fetchCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h3C80;
      16'd1:   return 16'h1A00;
      16'd2:   return 16'h0881;
      16'd3:   return 16'h2C80;
      16'd7:   return 16'hC004;
      default: return {4'h1, a[11:0]};
    endcase
  endfunction

  assign instruction = mem_f(PC);

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .PC(PC),
    .instruction(instruction),
    .redirect(redirect),
    .redirectPC(redirectPC),
    .outValid(outValid),
    .outReady(outReady),
    .outInstr(outInstr),
    .outPC(outPC),
    .outJumpTaken(outJumpTaken),
    .fetchCount(fetchCount)
  );

`ifdef FETCH_JUMP_PREDECODE_EN
  localparam logic        JT_EXP   = 1'b1;
  localparam logic [15:0] AFTER_J  = 16'd4;
  localparam logic [15:0] AFTER_J2 = 16'd5;
`else
  localparam logic        JT_EXP   = 1'b0;
  localparam logic [15:0] AFTER_J  = 16'd8;
  localparam logic [15:0] AFTER_J2 = 16'd9;
`endif

  task automatic test_reset();
    reset = 1'b1;
    outReady = 1'b0;
    redirect = 1'b0;
    redirectPC = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if (PC !== 16'h0000 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pc_valid: PC=%h v=%b, required 0000 0", PC, outValid);
    end
    checks++;
    if (fetchCount !== 16'h0000 || outJumpTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt_jt: cnt=%h jt=%b, required 0000 0",
               fetchCount, outJumpTaken);
    end
  endtask

  task automatic test_sequential();
    sb.push_back('{16'h0000, 16'h3C80});
    sb.push_back('{16'h0001, 16'h1A00});
    reset = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outValid !== 1'b1) begin
        errors++;
        $display("FAIL seq_valid: cycle %0d valid=%b, required 1", i, outValid);
      end
      if (outValid && outReady) begin
        checks++;
        e = sb.pop_front();
        if (outPC !== e.pc || outInstr !== e.ins) begin
          errors++;
          $display("FAIL seq_sb: pc=%h ins=%h, required pc=%h ins=%h",
                   outPC, outInstr, e.pc, e.ins);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outReady = 1'b0;
      checks++;
      if (outValid !== 1'b1 || outPC !== 16'd2 ||
          outInstr !== 16'h0881 || PC !== 16'd3) begin
        errors++;
        $display("FAIL stall_hold: v=%b pc=%h ins=%h PC=%h, required 1 0002 0881 0003",
                 outValid, outPC, outInstr, PC);
      end
    end
    sb.push_back('{16'h0002, 16'h0881});
    sb.push_back('{16'h0003, 16'h2C80});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      outReady = 1'b1;
      if (i == 1) begin
        checks++;
        if (fetchCount !== 16'd4) begin
          errors++;
          $display("FAIL stall_count: cnt=%0d, required 4", fetchCount);
        end
      end
      if (outValid && outReady) begin
        checks++;
        e = sb.pop_front();
        if (outPC !== e.pc || outInstr !== e.ins) begin
          errors++;
          $display("FAIL stall_sb: pc=%h ins=%h, required pc=%h ins=%h",
                   outPC, outInstr, e.pc, e.ins);
        end
      end
    end
  endtask

  task automatic test_redirect_stall();
    @(negedge clk);
    outReady = 1'b0;
    redirect = 1'b1;
    redirectPC = 16'h0006;
    checks++;
    if (outValid !== 1'b1 || outPC !== 16'd4) begin
      errors++;
      $display("FAIL redir_pre: v=%b pc=%h, required 1 0004", outValid, outPC);
    end
    @(negedge clk);
    redirect = 1'b0;
    outReady = 1'b1;
    checks++;
    if (outValid !== 1'b0 || PC !== 16'h0006) begin
      errors++;
      $display("FAIL redir_bubble: v=%b PC=%h, required 0 0006", outValid, PC);
    end
    sb.push_back('{16'h0006, mem_f(16'h0006)});
    @(negedge clk);
    if (outValid && outReady) begin
      checks++;
      e = sb.pop_front();
      if (outPC !== e.pc || outInstr !== e.ins) begin
        errors++;
        $display("FAIL redir_sb: pc=%h ins=%h, required pc=%h ins=%h",
                 outPC, outInstr, e.pc, e.ins);
      end
    end
  endtask

  task automatic test_jump();
    sb.push_back('{16'h0007, 16'hC004});
    sb.push_back('{AFTER_J, mem_f(AFTER_J)});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outJumpTaken !== ((i == 0) ? JT_EXP : 1'b0)) begin
        errors++;
        $display("FAIL jump_flag: cycle %0d jt=%b, required %b",
                 i, outJumpTaken, (i == 0) ? JT_EXP : 1'b0);
      end
      if (outValid && outReady) begin
        checks++;
        e = sb.pop_front();
        if (outPC !== e.pc || outInstr !== e.ins) begin
          errors++;
          $display("FAIL jump_sb: pc=%h ins=%h, required pc=%h ins=%h",
                   outPC, outInstr, e.pc, e.ins);
        end
      end
    end
  endtask

  task automatic test_wrap();
    sb.push_back('{AFTER_J2, mem_f(AFTER_J2)});
    sb.push_back('{16'hFFFF, 16'h1FFF});
    sb.push_back('{16'h0000, 16'h3C80});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      redirect = (i == 0);
      redirectPC = 16'hFFFF;
      if (i == 1) begin
        checks++;
        if (outValid !== 1'b0 || PC !== 16'hFFFF) begin
          errors++;
          $display("FAIL wrap_bubble: v=%b PC=%h, required 0 ffff", outValid, PC);
        end
      end
      if (i == 3) begin
        checks++;
        if (PC !== 16'h0001) begin
          errors++;
          $display("FAIL wrap_pc: PC=%h, required 0001", PC);
        end
      end
      if (outValid && outReady) begin
        checks++;
        e = sb.pop_front();
        if (outPC !== e.pc || outInstr !== e.ins) begin
          errors++;
          $display("FAIL wrap_sb: pc=%h ins=%h, required pc=%h ins=%h",
                   outPC, outInstr, e.pc, e.ins);
        end
      end
    end
  endtask

  task automatic test_saturation();
    outReady = 1'b1;
    repeat (65600) @(negedge clk);
    checks++;
    if (fetchCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: cnt=%h, required ffff", fetchCount);
    end
    @(negedge clk);
    checks++;
    if (fetchCount !== 16'hFFFF || outValid !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: cnt=%h v=%b, required ffff 1", fetchCount, outValid);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [15:0] pc_s;
    outReady = 1'b0;
    @(negedge clk);
    pc_s = PC;
    @(negedge clk);
    checks++;
    if (PC !== pc_s || outValid !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall_pre: PC=%h v=%b, required %h 1", PC, outValid, pc_s);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (PC !== 16'h0000 || outValid !== 1'b0 || fetchCount !== 16'h0000) begin
      errors++;
      $display("FAIL rst_stall: PC=%h v=%b cnt=%h, required 0000 0 0000",
               PC, outValid, fetchCount);
    end
    checks++;
    if (outPC !== 16'h0000 || outInstr !== 16'h0000 || outJumpTaken !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall_regs: pc=%h ins=%h jt=%b, required 0000 0000 0",
               outPC, outInstr, outJumpTaken);
    end
    reset = 1'b0;
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    redirect = 1'b1;
    redirectPC = 16'h1234;
    @(negedge clk);
    redirect = 1'b0;
    reset = 1'b0;
    checks++;
    if (PC !== 16'h0000 || outValid !== 1'b0 || fetchCount !== 16'h0000) begin
      errors++;
      $display("FAIL rst_redir: PC=%h v=%b cnt=%h, required 0000 0 0000",
               PC, outValid, fetchCount);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_jump();
    test_wrap();
    test_saturation();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
